// File: rtl/fa_nbit_seq_if.sv
// Operand/result bus of the chunked adder/subtractor: a valid/ready handshake on the
// operand side and another on the result side.
`timescale 1ns/1ps
interface fa_nbit_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;

    modport master (
        output in_valid, a, b, ci, sub, out_ready,
        input  in_ready, out_valid, s, co, ovf
    );

    modport slave (
        input  in_valid, a, b, ci, sub, out_ready,
        output in_ready, out_valid, s, co, ovf
    );
endinterface

// File: rtl/fa_nbit_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor that processes CHUNK bits per clock and
// holds the inter-chunk carry in a register.
`timescale 1ns/1ps
module fa_nbit_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic          clk,
    input  logic          rst,
    fa_nbit_seq_if.slave  bus
);
    localparam int N   = WIDTH / CHUNK;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic             carry_reg, carry_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] res_reg, res_next;
    logic [WIDTH-1:0] s_reg, s_next;
    logic             co_reg, co_next;
    logic             ovf_reg, ovf_next;

    logic [CHUNK-1:0] a_chunks [N];
    logic [CHUNK-1:0] b_chunks [N];
    logic [CHUNK-1:0] a_sel;
    logic [CHUNK-1:0] b_sel;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] res_merged;
    logic             last_chunk;

    // Slice the latched operands into chunks and splice the current chunk sum into
    // the partial result; on the last chunk res_merged is the complete result.
    for (genvar gi = 0; gi < N; gi++) begin : g_chunk
        assign a_chunks[gi] = a_reg[gi*CHUNK +: CHUNK];
        assign b_chunks[gi] = b_reg[gi*CHUNK +: CHUNK];
        assign res_merged[gi*CHUNK +: CHUNK] =
            (cnt_reg == CW'(gi)) ? chunk_sum[CHUNK-1:0] : res_reg[gi*CHUNK +: CHUNK];
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_reg == CW'(i)) begin
                a_sel = a_chunks[i];
                b_sel = b_chunks[i];
            end
        end
    end

    assign chunk_sum  = {1'b0, a_sel} + {1'b0, b_sel} + {{CHUNK{1'b0}}, carry_reg};
    assign last_chunk = (cnt_reg == CW'(N - 1));

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        carry_next = carry_reg;
        cnt_next   = cnt_reg;
        res_next   = res_reg;
        s_next     = s_reg;
        co_next    = co_reg;
        ovf_next   = ovf_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    // Subtraction is a + ~b + ~ci, so co=1 means "no borrow".
                    a_next     = bus.a;
                    b_next     = bus.sub ? ~bus.b : bus.b;
                    carry_next = bus.ci ^ bus.sub;
                    cnt_next   = '0;
                    state_next = CALC;
                end
            end
            CALC: begin
                res_next   = res_merged;
                carry_next = chunk_sum[CHUNK];
                cnt_next   = cnt_reg + CW'(1);
                if (last_chunk) begin
                    s_next     = res_merged;
                    co_next    = chunk_sum[CHUNK];
                    ovf_next   = (a_reg[MSB] == b_reg[MSB]) && (res_merged[MSB] != a_reg[MSB]);
                    cnt_next   = '0;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            res_reg   <= '0;
            s_reg     <= '0;
            co_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            carry_reg <= carry_next;
            cnt_reg   <= cnt_next;
            res_reg   <= res_next;
            s_reg     <= s_next;
            co_reg    <= co_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.s         = s_reg;
    assign bus.co        = co_reg;
    assign bus.ovf       = ovf_reg;
endmodule

// File: tb/tb_fa_nbit_seq.sv
// Self-checking bench for fa_nbit_seq: directed vector table, handshake/reset corner
// sequences, and random operations against a behavioural arithmetic model.
`timescale 1ns/1ps
module tb_fa_nbit_seq;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    logic rst_x;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fa_nbit_seq_if #(.WIDTH(W)) bus ();
    fa_nbit_seq #(.WIDTH(W), .CHUNK(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic          sub;
        logic          ci;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [W-1:0]  s;
        logic          co;
        logic          ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns {ovf, co, s} from plain integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic sub);
        int          sa, sb, r;
        logic [16:0] u;
        logic        co, ovf;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!sub) begin
            u  = {1'b0, a} + {1'b0, b} + 17'(ci);
            co = u[16];
            r  = sa + sb + int'(ci);
        end else begin
            u  = {1'b0, a} - {1'b0, b} - 17'(ci);
            co = ({1'b0, a} >= ({1'b0, b} + 17'(ci)));
            r  = sa - sb - int'(ci);
        end
        ovf = (r > 32767) || (r < -32768);
        return {ovf, co, u[15:0]};
    endfunction

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic sub, input int dly,
                         output logic [W-1:0] s, output logic co, output logic ovf, output int lat);
        bus.a = a; bus.b = b; bus.ci = ci; bus.sub = sub; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.a = 16'($urandom()); bus.b = 16'($urandom()); bus.ci = ~ci; bus.sub = ~sub;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        repeat (dly) tick();
        s = bus.s; co = bus.co; ovf = bus.ovf;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        vec_t          vecs [8];
        logic [W-1:0]  rs;
        logic          rco, rovf;
        int            lat;
        int            bad_hold, bad_ir, bad_ov, spurious, guard;
        logic [W-1:0]  ra, rb;
        logic          rci, rsub;
        logic [17:0]   exp;

        vecs[0] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 16'h7FFF, 16'h0000, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 16'h1234, 16'h4321, 16'h5556, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 16'h0010, 16'h000F, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};

        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.ci = 1'b0; bus.sub = 1'b0;
        rst = 1'b1; rst_x = 1'b1;
        tick();
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_s", 32'(bus.s), 0);
        check("rst_co", 32'(bus.co), 0);
        check("rst_ovf", 32'(bus.ovf), 0);
        rst = 1'b0; rst_x = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, i % 3, rs, rco, rovf, lat);
            $display("vec%0d sub=%0d a=%h b=%h ci=%0d -> s=%h co=%0d ovf=%0d lat=%0d",
                     i, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].ci, rs, rco, rovf, lat);
            check($sformatf("vec%0d_s", i), 32'(rs), 32'(vecs[i].s));
            check($sformatf("vec%0d_co", i), 32'(rco), 32'(vecs[i].co));
            check($sformatf("vec%0d_ovf", i), 32'(rovf), 32'(vecs[i].ovf));
            check($sformatf("vec%0d_latency", i), 32'(lat), 4);
        end

        // Backpressure: result must hold while the producer side keeps wiggling.
        bus.a = 16'h8000; bus.b = 16'h0001; bus.ci = 1'b0; bus.sub = 1'b1; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin tick(); lat++; end
        check("bp_latency", 32'(lat), 4);
        bad_hold = 0; bad_ir = 0; bad_ov = 0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = ~bus.in_valid;
            bus.a = 16'($urandom()); bus.b = 16'($urandom());
            tick();
            if (bus.s !== 16'h7FFF || bus.co !== 1'b1 || bus.ovf !== 1'b1) bad_hold++;
            if (bus.in_ready !== 1'b0) bad_ir++;
            if (bus.out_valid !== 1'b1) bad_ov++;
        end
        $display("backpressure hold s=%h co=%0d ovf=%0d", bus.s, bus.co, bus.ovf);
        check("bp_result_hold", 32'(bad_hold), 0);
        check("bp_in_ready_low", 32'(bad_ir), 0);
        check("bp_out_valid_high", 32'(bad_ov), 0);
        bus.a = 16'hC000; bus.b = 16'h8000; bus.ci = 1'b0; bus.sub = 1'b0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_idle_in_ready", 32'(bus.in_ready), 1);
        check("bp_idle_out_valid", 32'(bus.out_valid), 0);
        tick();
        bus.in_valid = 1'b0;
        check("bp_accept_in_ready", 32'(bus.in_ready), 0);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin tick(); lat++; end
        $display("post-bp op a=c000 b=8000 -> s=%h co=%0d ovf=%0d lat=%0d", bus.s, bus.co, bus.ovf, lat);
        check("bp_next_latency", 32'(lat), 4);
        check("bp_next_result", {14'd0, bus.ovf, bus.co, bus.s}, {14'd0, 1'b1, 1'b1, 16'h4000});
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Reset sampled on the second CALC edge discards the operation.
        bus.a = 16'h1234; bus.b = 16'h4321; bus.ci = 1'b1; bus.sub = 1'b0; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("mid-op reset in_ready=%0d out_valid=%0d s=%h co=%0d ovf=%0d",
                 bus.in_ready, bus.out_valid, bus.s, bus.co, bus.ovf);
        check("midrst_in_ready", 32'(bus.in_ready), 1);
        check("midrst_out_valid", 32'(bus.out_valid), 0);
        check("midrst_s", 32'(bus.s), 0);
        check("midrst_co", 32'(bus.co), 0);
        check("midrst_ovf", 32'(bus.ovf), 0);
        spurious = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.out_valid !== 1'b0) spurious++;
        end
        check("midrst_no_out_valid", 32'(spurious), 0);

        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom()); rb = 16'($urandom());
            rci = 1'($urandom()); rsub = 1'($urandom());
            if (i % 10 == 0) ra = 16'hFFFF;
            if (i % 10 == 1) rb = 16'h8000;
            exp = model(ra, rb, rci, rsub);
            do_op(ra, rb, rci, rsub, int'($urandom_range(0, 3)), rs, rco, rovf, lat);
            $display("rnd4 #%0d sub=%0d a=%h b=%h ci=%0d -> s=%h co=%0d ovf=%0d lat=%0d",
                     i, rsub, ra, rb, rci, rs, rco, rovf, lat);
            check($sformatf("rnd4_%0d_result", i), {14'd0, rovf, rco, rs}, {14'd0, exp});
            check($sformatf("rnd4_%0d_latency", i), 32'(lat), 4);
        end

        guard = 0;
        while (!(g_x[0].done_x && g_x[1].done_x) && guard < 20000) begin
            tick();
            guard++;
        end
        check("other_chunks_done", {30'd0, g_x[1].done_x, g_x[0].done_x}, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Single-cycle (CHUNK=16) and bit-serial (CHUNK=1) instances with random traffic.
    for (genvar gi = 0; gi < 2; gi++) begin : g_x
        localparam int CH = (gi == 0) ? 16 : 1;
        localparam int NX = W / CH;

        bit done_x = 1'b0;
        fa_nbit_seq_if #(.WIDTH(W)) xb ();
        fa_nbit_seq #(.WIDTH(W), .CHUNK(CH)) dut_x (.clk(clk), .rst(rst_x), .bus(xb));

        initial begin
            logic [W-1:0] ra, rb, rs;
            logic         rci, rsub, rco, rovf;
            logic [17:0]  exp;
            int           lat, g;
            xb.in_valid = 1'b0; xb.out_ready = 1'b0;
            xb.a = '0; xb.b = '0; xb.ci = 1'b0; xb.sub = 1'b0;
            g = 0;
            tick();
            while (rst_x !== 1'b0 && g < 100) begin tick(); g++; end
            for (int i = 0; i < 150; i++) begin
                ra = 16'($urandom()); rb = 16'($urandom());
                rci = 1'($urandom()); rsub = 1'($urandom());
                exp = model(ra, rb, rci, rsub);
                xb.a = ra; xb.b = rb; xb.ci = rci; xb.sub = rsub; xb.in_valid = 1'b1;
                tick();
                xb.in_valid = 1'b0;
                xb.a = ~ra; xb.b = ~rb;
                lat = 0;
                while (!xb.out_valid && lat < 60) begin tick(); lat++; end
                repeat ($urandom_range(0, 2)) tick();
                rs = xb.s; rco = xb.co; rovf = xb.ovf;
                xb.out_ready = 1'b1;
                tick();
                xb.out_ready = 1'b0;
                $display("rnd%0d #%0d sub=%0d a=%h b=%h ci=%0d -> s=%h co=%0d ovf=%0d lat=%0d",
                         CH, i, rsub, ra, rb, rci, rs, rco, rovf, lat);
                check($sformatf("rnd%0d_%0d_result", CH, i), {14'd0, rovf, rco, rs}, {14'd0, exp});
                check($sformatf("rnd%0d_%0d_latency", CH, i), 32'(lat), 32'(NX));
            end
            done_x = 1'b1;
        end
    end
endmodule
